fft_input_loader: RTL and testbench
===================================

Name: fft_input_loader

Overview:
- Host-to-FFT direction of the sample-buffer path: Wishbone writes fill an internal sample RAM, then a start pulse streams the buffer to the FFT core over a valid/ready interface.
- Complements the FFT-to-host result buffer: there the FFT writes and Wishbone reads; here Wishbone writes and the FFT reads.
- Sits between the Wishbone slave decode and the FFT datapath input.

Parameters:
- ADDR_W, 10, address width; buffer depth and stream length DEPTH = 2**ADDR_W.
- DATA_W, 32, sample word width (packed re/im).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_W  word address.
- wb_dat_i  in  DATA_W  write data.
- wb_dat_o  out  DATA_W  read data, valid with wb_ack_o.
- wb_ack_o  out  1  transfer acknowledge.
- start_i  in  1  begin streaming; sampled only in IDLE.
- fft_dat_o  out  DATA_W  stream sample.
- fft_valid_o  out  1  sample valid.
- fft_ready_i  in  1  FFT accepts the sample.
- fft_last_o  out  1  marks sample DEPTH-1.
- busy_o  out  1  high in STREAM.
- done_o  out  1  one-cycle pulse after the last handshake.
- overrun_o  out  1  sticky: a host write was dropped during STREAM.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0. RAM contents are not cleared.
- Wishbone slave:
  - Request = cyc & stb & !wb_ack_o. ack is registered: high the cycle after the request, for exactly 1 cycle.
  - Writes in IDLE commit to RAM[wb_adr_i] on the request cycle.
  - Writes in STREAM are acked but dropped, and set overrun_o.
  - Reads return RAM[wb_adr_i] on wb_dat_o with ack, in any state; ack latency is 1 cycle.
  - wb_dat_o holds its last value otherwise.
- FSM IDLE -> STREAM:
  - start_i=1 in IDLE at cycle t: STREAM entered at t+1; busy_o=1 from t+1; overrun_o cleared at t+1.
  - A same-cycle Wishbone write at t is committed and visible to the stream.
- STREAM:
  - Read counter rd_idx issues RAM reads; RAM read latency is 1.
  - A 2-entry skid buffer feeds fft_dat_o/fft_valid_o.
  - First fft_valid_o at t+2; sustains 1 word/cycle while fft_ready_i=1.
  - While fft_valid_o=1 and fft_ready_i=0, fft_dat_o, fft_valid_o and fft_last_o hold stable.
  - Reads stop issuing at rd_idx = DEPTH-1; no wrap.
  - Output counter out_idx increments per handshake; fft_last_o = fft_valid_o & (out_idx == DEPTH-1).
- STREAM -> IDLE: on the handshake of the last word, next cycle: busy_o=0, fft_valid_o=0, done_o=1 for 1 cycle.
- start_i while in STREAM is ignored.
- rst mid-stream: immediate return to IDLE next edge; valid/last drop; no done_o.
- Arithmetic: counters are ADDR_W+1 bits unsigned, so termination compares without overflow.

Optional Feature:
- Macro BIT_REVERSE_EN.
- Defined: the RAM read address is bit-reversed rd_idx over ADDR_W bits, giving decimation-in-time input order. Wishbone addressing is unaffected.
- Undefined: natural order, RAM read address = rd_idx.

Decomposition:
- Package fft_loader_pkg: state enum (IDLE, STREAM), default ADDR_W/DATA_W constants, bit-reverse function.
- Sub-module fft_sample_ram: simple dual-port, one write port, one registered read port, DEPTH x DATA_W, read-during-write to the same address returns old data.
- Wishbone read shares the stream read port, muxed by state. In STREAM, Wishbone read is deferred while a stream read issues; ack then arrives at most 2 cycles after the request.

Test Plan:
- Reset: assert rst 3 cycles -> all outputs 0; Wishbone read of addr 7 after reset acks 1 cycle later.
- Fill/readback: write RAM[i]=3*i for i=0..1023, read addr 5 -> wb_dat_o=15, each ack exactly 1 cycle after the request.
- Full-rate stream: start at t, ready held 1 -> valid at t+2; samples 0,3,6..3069 on consecutive cycles; last with 3069; done_o at the cycle after; busy_o 0.
- Backpressure: ready pattern 1,0,0,1,0,1... -> data stable while stalled; exactly 1024 handshakes; no duplicate or missing words.
- Overrun and mid-stream reset: Wishbone write during STREAM -> acked, RAM unchanged, overrun_o=1 until next start. Then rst at sample 500 -> valid 0 next cycle, no done_o, IDLE.
- BIT_REVERSE_EN with ADDR_W=3, RAM[i]=i -> stream order 0,4,2,6,1,5,3,7; without the macro -> 0..7.

Source files
------------

// File: rtl/fft_input_loader_pkg.sv
// Shared types and helpers for the FFT input loader.
// Default sample-buffer geometry, the stream FSM state type, and the
// address bit-reversal used when BIT_REVERSE_EN is defined.
package fft_loader_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;

  // Widest address the bit-reversal helper can handle.
  localparam int MAX_ADDR_W = 16;
  localparam int MAX_IDX_W  = $clog2(MAX_ADDR_W);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Reverse the low 'width' bits of 'value'; bits at and above 'width' come back as 0.
  function automatic logic [MAX_ADDR_W-1:0] bit_reverse(input logic [MAX_ADDR_W-1:0] value,
                                                         input int unsigned width);
    logic [MAX_ADDR_W-1:0] result;
    result = '0;
    for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
      if (i < width) begin
        result[MAX_IDX_W'(i)] = value[MAX_IDX_W'(width - 1 - i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Bus bundle for the FFT input loader: the Wishbone slave port on the host
// side and the valid/ready sample stream towards the FFT core.
// The slave modport is the loader's view, the master modport the host/FFT view.
interface fft_input_loader_if
  import fft_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  logic [DATA_W-1:0] fft_dat_o;
  logic              fft_valid_o;
  logic              fft_ready_i;
  logic              fft_last_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, fft_ready_i,
    output wb_dat_o, wb_ack_o, fft_dat_o, fft_valid_o, fft_last_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, fft_ready_i,
    input  wb_dat_o, wb_ack_o, fft_dat_o, fft_valid_o, fft_last_o
  );

endinterface

// File: rtl/fft_input_loader_ram.sv
// Sample RAM for the FFT input loader: simple dual-port, one write port and
// one registered read port. A read and a write to the same address in the
// same cycle return the old contents.
module fft_sample_ram
  import fft_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port; non-blocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input loader: the host fills the sample RAM over Wishbone, then a start
// pulse streams the whole buffer to the FFT core over valid/ready.
// The RAM read port is shared between the stream and Wishbone reads; a
// Wishbone read that collides with a stream read waits one cycle and then
// takes priority. A 2-entry skid buffer behind the RAM keeps the stream
// output stable under backpressure while allowing one word per cycle.
// Optional build macro: BIT_REVERSE_EN streams the buffer in bit-reversed
// address order (decimation-in-time input order) instead of natural order.
module fft_input_loader
  import fft_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  fft_input_loader_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t LAST_C  = cnt_t'(DEPTH - 1);

  state_t state_q, state_d;

  cnt_t rd_idx_q;
  cnt_t out_idx_q;

  logic [DATA_W-1:0] skid_q [2];
  logic              skid_wr_q;
  logic              skid_rd_q;
  logic [1:0]        skid_cnt_q;
  logic              ram_vld_q;

  logic              wb_ack_q;
  logic              wb_rd_ack_q;
  logic              wb_defer_q;
  logic [DATA_W-1:0] wb_hold_q;
  logic              overrun_q;
  logic              done_q;

  logic              in_stream;
  logic              wb_req;
  logic              wb_wr_req;
  logic              wb_rd_req;
  logic              skid_empty;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              pop;
  logic              pop_skid;
  logic              push_skid;
  logic [2:0]        occ_after;
  logic              stream_want;
  logic              stream_issue;
  logic              wb_rd_issue;
  logic              last_hs;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] stream_addr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_q;

  assign in_stream = (state_q == STREAM);

  assign wb_req    = bus.wb_cyc_i & bus.wb_stb_i & ~wb_ack_q;
  assign wb_wr_req = wb_req & bus.wb_we_i;
  assign wb_rd_req = wb_req & ~bus.wb_we_i;

  assign skid_empty = (skid_cnt_q == 2'd0);
  assign out_valid  = in_stream & (~skid_empty | ram_vld_q);
  assign out_data   = skid_empty ? ram_q : skid_q[skid_rd_q];
  assign pop        = out_valid & bus.fft_ready_i;
  assign pop_skid   = pop & ~skid_empty;
  assign push_skid  = ram_vld_q & ~(skid_empty & pop);

  // Words still held after this cycle's handshake; a new read is only issued
  // while at most one remains, so the skid buffer can never overflow.
  assign occ_after = {1'b0, skid_cnt_q} + {2'b00, ram_vld_q} - {2'b00, pop};

  assign stream_want  = in_stream & (rd_idx_q < DEPTH_C) & (occ_after <= 3'd1);
  assign stream_issue = stream_want & ~(wb_rd_req & wb_defer_q);
  assign wb_rd_issue  = wb_rd_req & (~stream_want | wb_defer_q);

  assign last_hs = pop & (out_idx_q == LAST_C);

`ifdef BIT_REVERSE_EN
  assign stream_addr = ADDR_W'(bit_reverse(MAX_ADDR_W'(rd_idx_q[ADDR_W-1:0]), ADDR_W));
`else
  assign stream_addr = rd_idx_q[ADDR_W-1:0];
`endif

  assign ram_we    = wb_wr_req & ~in_stream;
  assign ram_re    = stream_issue | wb_rd_issue;
  assign ram_raddr = stream_issue ? stream_addr : bus.wb_adr_i;

  fft_sample_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (bus.wb_adr_i),
    .wr_data (bus.wb_dat_i),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_q)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start launches a stream, the last handshake ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = STREAM;
      STREAM:  if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream counters, skid bookkeeping, Wishbone handshake and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx_q    <= '0;
      out_idx_q   <= '0;
      skid_wr_q   <= 1'b0;
      skid_rd_q   <= 1'b0;
      skid_cnt_q  <= 2'd0;
      ram_vld_q   <= 1'b0;
      wb_ack_q    <= 1'b0;
      wb_rd_ack_q <= 1'b0;
      wb_defer_q  <= 1'b0;
      wb_hold_q   <= '0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= last_hs;
      wb_ack_q    <= wb_wr_req | wb_rd_issue;
      wb_rd_ack_q <= wb_rd_issue;
      wb_defer_q  <= wb_rd_req & stream_want & ~wb_defer_q;
      ram_vld_q   <= stream_issue;

      if (wb_rd_ack_q) begin
        wb_hold_q <= ram_q;
      end

      if (!in_stream && start_i) begin
        overrun_q <= 1'b0;
      end else if (in_stream && wb_wr_req) begin
        overrun_q <= 1'b1;
      end

      if (!in_stream || last_hs) begin
        rd_idx_q   <= '0;
        out_idx_q  <= '0;
        skid_wr_q  <= 1'b0;
        skid_rd_q  <= 1'b0;
        skid_cnt_q <= 2'd0;
      end else begin
        if (stream_issue) begin
          rd_idx_q <= rd_idx_q + cnt_t'(1);
        end
        if (pop) begin
          out_idx_q <= out_idx_q + cnt_t'(1);
        end
        if (push_skid) begin
          skid_wr_q <= ~skid_wr_q;
        end
        if (pop_skid) begin
          skid_rd_q <= ~skid_rd_q;
        end
        skid_cnt_q <= skid_cnt_q + {1'b0, push_skid} - {1'b0, pop_skid};
      end
    end
  end

  // Skid buffer storage: capture RAM data that was not consumed directly.
  always_ff @(posedge clk) begin
    if (in_stream && push_skid) begin
      skid_q[skid_wr_q] <= ram_q;
    end
  end

  assign bus.wb_ack_o    = wb_ack_q;
  assign bus.wb_dat_o    = wb_rd_ack_q ? ram_q : wb_hold_q;
  assign bus.fft_valid_o = out_valid;
  assign bus.fft_dat_o   = out_valid ? out_data : '0;
  assign bus.fft_last_o  = out_valid & (out_idx_q == LAST_C);

  assign busy_o    = in_stream;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed self-checking bench for fft_input_loader.
// Main instance uses ADDR_W=10; a second ADDR_W=3 instance checks the
// stream order (bit-reversed when BIT_REVERSE_EN is defined).
module tb_fft_input_loader;
  import fft_loader_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic overrun;
  logic start_s;
  logic busy_s;
  logic done_s;
  logic overrun_s;

  int n_checks;
  int n_fails;

  fft_input_loader_if #(.ADDR_W(10), .DATA_W(32)) bus   ();
  fft_input_loader_if #(.ADDR_W(3),  .DATA_W(32)) bus_s ();

  fft_input_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .overrun_o (overrun),
    .bus       (bus)
  );

  fft_input_loader #(.ADDR_W(3), .DATA_W(32)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_s),
    .busy_o    (busy_s),
    .done_o    (done_s),
    .overrun_o (overrun_s),
    .bus       (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it and report any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wbWrite(input logic [9:0] addr, input logic [31:0] data, input bit chk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = addr;
    bus.wb_dat_i = data;
    @(posedge clk); #1;
    if (chk) checkOutput("wr_ack_1cyc", 64'(bus.wb_ack_o), 64'd1);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wbRead(input logic [9:0] addr, output logic [31:0] data, output int lat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = addr;
    lat  = 0;
    data = '0;
    while (lat < 4) begin
      @(posedge clk); #1;
      lat++;
      if (bus.wb_ack_o) break;
    end
    data = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Start a stream on the main instance and follow it to completion or to a reset at sample rst_at.
  task automatic applyStimulus(input string tag, input bit stall, input int rst_at);
    int k, cycles, bad, unstable, gaps, last_pos;
    bit prev_stall;
    logic [31:0] prev_dat;
    logic prev_last;
    logic [5:0] pat;
    pat = 6'b101001;
    k = 0; cycles = 0; bad = 0; unstable = 0; gaps = 0; last_pos = -1;
    prev_stall = 1'b0; prev_dat = '0; prev_last = 1'b0;
    start = 1'b1;
    bus.fft_ready_i = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy_t1"},    64'(busy), 64'd1);
    checkOutput({tag, "_ovr_clr_t1"}, 64'(overrun), 64'd0);
    checkOutput({tag, "_valid_t1"},   64'(bus.fft_valid_o), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid_t2"},   64'(bus.fft_valid_o), 64'd1);
    while (k < 1024 && cycles < 5000) begin
      bus.fft_ready_i = stall ? pat[3'(cycles % 6)] : 1'b1;
      if (prev_stall && (!bus.fft_valid_o || bus.fft_dat_o != prev_dat || bus.fft_last_o != prev_last))
        unstable++;
      prev_stall = 1'b0;
      if (rst_at >= 0 && k == rst_at && bus.fft_valid_o) break;
      if (bus.fft_valid_o && bus.fft_ready_i) begin
        if (bus.fft_dat_o != 32'(3 * k)) bad++;
        if (bus.fft_last_o != (k == 1023)) bad++;
        if (bus.fft_last_o) last_pos = k;
        k++;
      end else if (bus.fft_valid_o) begin
        prev_stall = 1'b1;
        prev_dat   = bus.fft_dat_o;
        prev_last  = bus.fft_last_o;
      end else begin
        gaps++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_data_errs"}, 64'(bad), 64'd0);
    checkOutput({tag, "_unstable"},  64'(unstable), 64'd0);
    if (rst_at >= 0) begin
      checkOutput({tag, "_k_at_rst"}, 64'(k), 64'(rst_at));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput({tag, "_valid_after_rst"}, 64'(bus.fft_valid_o), 64'd0);
      checkOutput({tag, "_last_after_rst"},  64'(bus.fft_last_o), 64'd0);
      checkOutput({tag, "_busy_after_rst"},  64'(busy), 64'd0);
      checkOutput({tag, "_done_after_rst"},  64'(done), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_done_after_rst2"}, 64'(done), 64'd0);
      checkOutput({tag, "_busy_after_rst2"}, 64'(busy), 64'd0);
    end else begin
      checkOutput({tag, "_handshakes"}, 64'(k), 64'd1024);
      checkOutput({tag, "_last_pos"},   64'(last_pos), 64'd1023);
      if (!stall) checkOutput({tag, "_gaps"}, 64'(gaps), 64'd0);
      checkOutput({tag, "_done_pulse"}, 64'(done), 64'd1);
      checkOutput({tag, "_busy_end"},   64'(busy), 64'd0);
      checkOutput({tag, "_valid_end"},  64'(bus.fft_valid_o), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_done_1cyc"},  64'(done), 64'd0);
    end
    bus.fft_ready_i = 1'b0;
  endtask

  // Abort guard in case the run stops making progress.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, fill/readback, full-rate, backpressure, overrun, mid-stream reset, order.
  initial begin
    logic [31:0] rdat;
    int lat;
    logic [31:0] exp_order [8];
    logic [31:0] got_s [8];
    logic        got_last_s [8];
    int n, cycles;

    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.fft_ready_i = 1'b0;
    bus_s.wb_cyc_i = 1'b0; bus_s.wb_stb_i = 1'b0; bus_s.wb_we_i = 1'b0;
    bus_s.wb_adr_i = '0; bus_s.wb_dat_i = '0; bus_s.fft_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack",     64'(bus.wb_ack_o), 64'd0);
    checkOutput("rst_wb_dat",  64'(bus.wb_dat_o), 64'd0);
    checkOutput("rst_valid",   64'(bus.fft_valid_o), 64'd0);
    checkOutput("rst_last",    64'(bus.fft_last_o), 64'd0);
    checkOutput("rst_fft_dat", 64'(bus.fft_dat_o), 64'd0);
    checkOutput("rst_busy",    64'(busy), 64'd0);
    checkOutput("rst_done",    64'(done), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    wbRead(10'd7, rdat, lat);
    checkOutput("rd7_latency", 64'(lat), 64'd1);

    for (int i = 0; i < 1024; i++) begin
      wbWrite(10'(i), 32'(3 * i), (i < 4));
    end
    wbRead(10'd5, rdat, lat);
    checkOutput("rd5_data",    64'(rdat), 64'd15);
    checkOutput("rd5_latency", 64'(lat), 64'd1);
    checkOutput("wb_dat_hold", 64'(bus.wb_dat_o), 64'd15);

    fork
      applyStimulus("full", 1'b0, -1);
      begin
        repeat (100) @(posedge clk);
        #1;
        wbWrite(10'd10, 32'hDEAD_BEEF, 1'b1);
        checkOutput("overrun_set", 64'(overrun), 64'd1);
      end
    join
    checkOutput("overrun_sticky", 64'(overrun), 64'd1);

    fork
      applyStimulus("bp", 1'b1, -1);
      begin
        repeat (100) @(posedge clk);
        #1;
        wbRead(10'd5, rdat, lat);
        checkOutput("stream_rd_data",   64'(rdat), 64'd15);
        checkOutput("stream_rd_lat_le2", 64'(lat <= 2), 64'd1);
      end
    join

    applyStimulus("midrst", 1'b0, 500);
    wbRead(10'd10, rdat, lat);
    checkOutput("dropped_wr_ram", 64'(rdat), 64'd30);

`ifdef BIT_REVERSE_EN
    exp_order = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
`else
    exp_order = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
`endif
    for (int i = 0; i < 8; i++) begin
      bus_s.wb_cyc_i = 1'b1;
      bus_s.wb_stb_i = 1'b1;
      bus_s.wb_we_i  = 1'b1;
      bus_s.wb_adr_i = 3'(i);
      bus_s.wb_dat_i = 32'(i);
      @(posedge clk); #1;
      bus_s.wb_cyc_i = 1'b0;
      bus_s.wb_stb_i = 1'b0;
      bus_s.wb_we_i  = 1'b0;
      @(posedge clk); #1;
    end
    start_s = 1'b1;
    bus_s.fft_ready_i = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 0;
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      got_s[i] = '0;
      got_last_s[i] = 1'b0;
    end
    while (n < 8 && cycles < 40) begin
      if (bus_s.fft_valid_o) begin
        got_s[n]      = bus_s.fft_dat_o;
        got_last_s[n] = bus_s.fft_last_o;
        n++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("order_count", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("order_%0d", i), 64'(got_s[i]), 64'(exp_order[i]));
    end
    checkOutput("order_last6", 64'(got_last_s[6]), 64'd0);
    checkOutput("order_last7", 64'(got_last_s[7]), 64'd1);
    checkOutput("order_done",  64'(done_s), 64'd1);
    bus_s.fft_ready_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
